irq_timer: RTL and testbench
============================

// Module: irq_timer
// PURPOSE
// - Programmable down-counting timer. It raises the hardware interrupt lines that cp0 samples on hwirq.
// - Memory-mapped on the data bus: the CPU writes CTRL/PRESET and reads COUNT.
// - Output irq drives one hwirq bit. cp0 acts on it only while that bit is unmasked and exl=0.
// PARAMETERS
// - RESET_PRESET  32'd0  value PRESET takes on reset
// - PRESCALE_W    8      width of CTRL prescale field; used only with TIMER_PRESCALE_EN
// PORTS
// - clk    in   1   system clock, all state on posedge
// - rst    in   1   reset; asynchronous, active-low (0 = reset)
// - addr   in   2   word select: 0=CTRL, 1=PRESET, 2=COUNT, 3=unused
// - we     in   1   write strobe, sampled on posedge clk
// - wdata  in   32  write data
// - rdata  out  32  combinational read of the register selected by addr
// - irq    out  1   interrupt request to cp0 hwirq, = CTRL.IM & pend
// BEHAVIOUR
// - CTRL fields
//   - [0] EN: enable
//   - [2:1] MODE: 00 = one-shot, 01 = auto-reload; 1x decodes as 00
//   - [3] IM: interrupt mask, 1 = irq allowed
//   - All other bits read 0.
// - PRESET: full 32-bit R/W.
// - COUNT: read-only; writes to it are ignored. addr 3 reads 0; writes to it are ignored.
// - Reset values: CTRL=0, PRESET=RESET_PRESET, COUNT=0, pend=0, state=IDLE, irq=0.
//   rdata follows from these values.
// - FSM states: IDLE, LOAD, CNT, INT.
//   - IDLE: if EN, next state is LOAD; otherwise stay.
//   - LOAD: COUNT<=PRESET; next state is CNT.
//   - CNT, EN=0: next state is IDLE; COUNT holds.
//   - CNT, COUNT>1: COUNT<=COUNT-1.
//   - CNT, COUNT<=1: COUNT<=0, pend<=1, next state is INT.
//   - INT, MODE=00: EN<=0, next state is IDLE. pend stays 1 (level irq) until any CTRL write.
//   - INT, MODE=01: pend<=0 (one-cycle pulse), next state is LOAD.
// - CTRL write, in any state
//   - Updates EN/MODE/IM, clears pend and forces next state to IDLE.
//   - The write takes priority over every FSM transition in that cycle, including setting pend.
// - PRESET write: takes effect at the next LOAD only; never alters a running COUNT.
// - PRESET=0 or 1: timer passes through LOAD, then one CNT cycle, then INT.
// - Latency, one-shot, PRESET=N>=1
//   - CTRL write (EN=1) in cycle 0 puts IDLE in cycle 1, LOAD in cycle 2, COUNT=N in cycle 3.
//   - irq goes high in cycle N+3.
// - Auto-reload: the irq pulse repeats every N+2 cycles.
// - COUNT arithmetic: unsigned 32-bit. It never underflows; the minimum is 0.
// - Reset mid-count: all state returns to reset values immediately (async); irq drops at once.
// - Clearing IM masks irq without losing pend. Setting IM later re-exposes a pending one-shot irq.
// CONFIGURATION
// - Macro TIMER_PRESCALE_EN defined:
//   - CTRL[8+:PRESCALE_W] = P, readable and writable.
//   - In CNT, COUNT decrements only every (P+1) cycles; P=0 gives identical timing to the macro-off build.
//   - The prescale counter is cleared in LOAD and on any CTRL write.
//   - The INT decision is taken on the decrement cycle that would leave COUNT<=1.
// - Macro TIMER_PRESCALE_EN undefined:
//   - CTRL[15:8] reads 0 and writes to it are ignored.
//   - COUNT decrements every CNT cycle.
// TESTING
// - Reset: rst=0 mid-count -> rdata(CTRL)=0, rdata(COUNT)=0, rdata(PRESET)=RESET_PRESET, irq=0 in the same cycle.
// - One-shot: PRESET=5, then CTRL=0x9 in cycle 0 -> irq=0 through cycle 7, 1 from cycle 8 onward;
//   EN reads 0 after INT; a CTRL write clears irq the next cycle.
// - Auto-reload: PRESET=3, CTRL=0xB -> single-cycle irq pulses exactly every 5 cycles, COUNT reloads to 3.
// - Mask and priority:
//   - CTRL=0x1 (IM=0) with PRESET=2 -> irq stays 0. Then write CTRL=0x8 -> pend is cleared by the write, irq stays 0.
//   - A CTRL write in the same cycle as CNT->INT -> pend=0, state=IDLE.
// - PRESET write mid-count: PRESET=10 running; write PRESET=2 at COUNT=7 -> COUNT continues 6,5,...; reload uses 2.
// - With TIMER_PRESCALE_EN: P=3, PRESET=2 -> COUNT changes every 4 cycles; one-shot irq in cycle 8 after the
//   cycle-0 CTRL write. P=0 -> matches the macro-off timing.

Source files
------------

// File: rtl/irq_timer.sv
// Memory-mapped down-counting interrupt timer: CTRL/PRESET/COUNT registers and a level/pulse irq.
// Optional prescaler on the count rate is built when TIMER_PRESCALE_EN is defined.
module irq_timer #(
  parameter logic [31:0] RESET_PRESET = 32'd0,
  parameter int          PRESCALE_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // state  | meaning
  // IDLE   | stopped, waits for CTRL.EN
  // LOAD   | COUNT <= PRESET
  // CNT    | counting down towards the terminal count
  // INT    | terminal count reached; one-shot stops, auto-reload re-arms
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        pend;
  logic [31:0] preset;
  logic [31:0] count;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        reload;
  logic        tick;
  logic [31:0] ctrl_rd;

`ifdef TIMER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc;
  logic [PRESCALE_W-1:0] psc_cnt;

  // Prescale down-counter ticks when it sits at zero, so P=0 ticks every cycle.
  assign tick = (psc_cnt == '0);
`else
  assign tick = 1'b1;
`endif

  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);
  // MODE 1x behaves as one-shot
  assign reload    = (mode == 2'b01);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      en     <= 1'b0;
      mode   <= 2'b00;
      im     <= 1'b0;
      pend   <= 1'b0;
      preset <= RESET_PRESET;
      count  <= 32'd0;
`ifdef TIMER_PRESCALE_EN
      psc     <= '0;
      psc_cnt <= '0;
`endif
    end else begin
      if (preset_wr) begin
        preset <= wdata;
      end

      if (ctrl_wr) begin
        // A CTRL write overrides whatever the FSM would have done this cycle.
        en    <= wdata[0];
        mode  <= wdata[2:1];
        im    <= wdata[3];
        pend  <= 1'b0;
        state <= S_IDLE;
`ifdef TIMER_PRESCALE_EN
        psc     <= wdata[8 +: PRESCALE_W];
        psc_cnt <= '0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            if (en) begin
              state <= S_LOAD;
            end
          end

          S_LOAD: begin
            count <= preset;
            state <= S_CNT;
`ifdef TIMER_PRESCALE_EN
            psc_cnt <= '0;
`endif
          end

          S_CNT: begin
            if (!en) begin
              state <= S_IDLE;
            end else begin
`ifdef TIMER_PRESCALE_EN
              if (tick) begin
                psc_cnt <= psc;
              end else begin
                psc_cnt <= psc_cnt - 1'b1;
              end
`endif
              if (tick) begin
                if (count > 32'd1) begin
                  count <= count - 32'd1;
                end else begin
                  count <= 32'd0;
                  pend  <= 1'b1;
                  state <= S_INT;
                end
              end
            end
          end

          S_INT: begin
            if (reload) begin
              pend  <= 1'b0;
              state <= S_LOAD;
            end else begin
              en    <= 1'b0;
              state <= S_IDLE;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ctrl_rd      = 32'd0;
    ctrl_rd[0]   = en;
    ctrl_rd[2:1] = mode;
    ctrl_rd[3]   = im;
`ifdef TIMER_PRESCALE_EN
    ctrl_rd[8 +: PRESCALE_W] = psc;
`else
    ctrl_rd[8 +: PRESCALE_W] = '0;
`endif
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_CTRL:   rdata = ctrl_rd;
      ADDR_PRESET: rdata = preset;
      ADDR_COUNT:  rdata = count;
      default:     rdata = 32'd0;
    endcase
  end

  assign irq = im & pend;

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: register access table plus cycle-exact timer sequences.
module tb_irq_timer;

  localparam logic [31:0] RST_PRESET = 32'h0000_0007;

  logic        clk;
  logic        rst;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int pass_cnt  = 0;
  int total_cnt = 0;

  irq_timer #(.RESET_PRESET(RST_PRESET), .PRESCALE_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [1:0]  ra;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[8];

`ifdef TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_MASKED = 32'h0000_FF06;
`else
  localparam logic [31:0] CTRL_MASKED = 32'h0000_0006;
`endif

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    chk(name, {31'd0, irq}, {31'd0, exp});
  endtask

  // Write strobe held for one cycle; returns one cycle after the write cycle.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    cyc();
    we    = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    addr  = 2'd0;
    we    = 1'b0;
    wdata = 32'd0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();

    vecs[0] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0,         "rst_ctrl"};
    vecs[1] = '{1'b0, 2'd0, 32'h0,         2'd1, RST_PRESET,    "rst_preset"};
    vecs[2] = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0,         "rst_count"};
    vecs[3] = '{1'b1, 2'd1, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF, "preset_rw"};
    vecs[4] = '{1'b1, 2'd2, 32'h0000_0055, 2'd2, 32'h0,         "count_ro"};
    vecs[5] = '{1'b1, 2'd3, 32'h1234_5678, 2'd3, 32'h0,         "addr3_zero"};
    vecs[6] = '{1'b1, 2'd0, 32'hFFFF_FF06, 2'd0, CTRL_MASKED,   "ctrl_fields"};
    vecs[7] = '{1'b1, 2'd0, 32'h0,         2'd0, 32'h0,         "ctrl_clear"};

    chk_irq("rst_irq", 1'b0);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].wa, vecs[i].wd);
      chk_rd(vecs[i].name, vecs[i].ra, vecs[i].exp);
    end

    // One-shot, PRESET=5: irq rises in cycle 8 and holds as a level.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 10; k++) begin
      chk_irq($sformatf("oneshot_irq_c%0d", k), k >= 8);
      if (k == 3) chk_rd("oneshot_count_c3", 2'd2, 32'd5);
      if (k == 7) chk_rd("oneshot_count_c7", 2'd2, 32'd1);
      cyc();
    end
    chk_irq("oneshot_level", 1'b1);
    chk_rd("oneshot_en_clear", 2'd0, 32'h8);
    wr(2'd0, 32'h8);
    chk_irq("oneshot_ctrl_clears", 1'b0);

    // Auto-reload, PRESET=3: single-cycle pulses every 5 cycles starting at cycle 6.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      chk_irq($sformatf("auto_irq_c%0d", k), (k >= 6) && ((k - 6) % 5 == 0));
      if (k == 8)  chk_rd("auto_reload_c8", 2'd2, 32'd3);
      if (k == 13) chk_rd("auto_reload_c13", 2'd2, 32'd3);
      cyc();
    end
    wr(2'd0, 32'h0);

    // IM=0 hides the interrupt; a later CTRL write drops the pending flag.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      chk_irq($sformatf("mask_irq_c%0d", k), 1'b0);
      cyc();
    end
    chk_rd("mask_en_clear", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    for (int k = 0; k < 3; k++) begin
      chk_irq($sformatf("mask_pend_cleared_%0d", k), 1'b0);
      cyc();
    end

    // CTRL write in the CNT->INT cycle wins over setting pend.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    repeat (6) cyc();
    chk_rd("prio_count_c7", 2'd2, 32'd1);
    wr(2'd0, 32'h8);
    for (int k = 8; k <= 11; k++) begin
      chk_irq($sformatf("prio_irq_c%0d", k), 1'b0);
      cyc();
    end
    chk_rd("prio_ctrl", 2'd0, 32'h8);

    // PRESET rewritten mid-count only affects the next reload.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'hB);
    repeat (5) cyc();
    chk_rd("mid_count_c6", 2'd2, 32'd7);
    wr(2'd1, 32'd2);
    for (int k = 7; k <= 17; k++) begin
      if (k <= 12) chk_rd($sformatf("mid_count_c%0d", k), 2'd2, 32'(13 - k));
      if (k == 15) chk_rd("mid_reload_c15", 2'd2, 32'd2);
      chk_irq($sformatf("mid_irq_c%0d", k), (k == 13) || (k == 17));
      cyc();
    end
    wr(2'd0, 32'h0);

    // PRESET=0 boundary: LOAD, one CNT cycle, INT -> irq in cycle 4.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      chk_irq($sformatf("p0_irq_c%0d", k), k >= 4);
      cyc();
    end

    // Async reset while irq is high takes effect without a clock edge.
    #2;
    rst = 1'b0;
    #1;
    chk_irq("async_rst_irq", 1'b0);
    chk_rd("async_rst_ctrl", 2'd0, 32'h0);
    chk_rd("async_rst_preset", 2'd1, RST_PRESET);
    chk_rd("async_rst_count", 2'd2, 32'h0);
    cyc();
    rst = 1'b1;
    cyc();

`ifdef TIMER_PRESCALE_EN
    // P=3, PRESET=2: COUNT steps every 4 cycles, irq in cycle 8.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h309);
    for (int k = 1; k <= 9; k++) begin
      chk_irq($sformatf("psc_irq_c%0d", k), k >= 8);
      if (k == 3) chk_rd("psc_count_c3", 2'd2, 32'd2);
      if (k == 4) chk_rd("psc_count_c4", 2'd2, 32'd1);
      if (k == 7) chk_rd("psc_count_c7", 2'd2, 32'd1);
      cyc();
    end
    wr(2'd0, 32'h0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
